// File: rtl/icache_axi_rd_bridge.sv
// Instruction-cache refill / uncached-read responder: turns one icache request
// into a single AXI4 read (4-beat INCR line or single-beat word) and returns it.
module icache_axi_rd_bridge #(
  parameter int unsigned LINE_WORD_NUM = 4,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter logic [3:0]  AXI_ID        = 4'd0
) (
  input  logic                                clk_g,
  input  logic                                rst,
  input  logic                                rd_req,
  input  logic                                rd_uncache,
  input  logic [31:0]                         rd_addr,
  output logic                                rd_rdy,
  output logic                                ret_valid,
  output logic [LINE_WORD_NUM*DATA_WIDTH-1:0] ret_data,
  output logic                                ret_err,
  output logic [3:0]                          arid,
  output logic [31:0]                         araddr,
  output logic [7:0]                          arlen,
  output logic [2:0]                          arsize,
  output logic [1:0]                          arburst,
  output logic                                arvalid,
  input  logic                                arready,
  input  logic [3:0]                          rid,
  input  logic [DATA_WIDTH-1:0]               rdata,
  input  logic [1:0]                          rresp,
  input  logic                                rlast,
  input  logic                                rvalid,
  output logic                                rready
);

  localparam int unsigned CW = (LINE_WORD_NUM > 1) ? $clog2(LINE_WORD_NUM) : 1;
  localparam int unsigned LW = LINE_WORD_NUM * DATA_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;
  localparam logic [1:0] S_RET  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          is_unc_q, is_unc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [LW-1:0] data_q, data_d;

  logic [CW-1:0] last_idx;
  logic          beat_last;

  // Uncached reads are single-beat, so their final beat index is always 0.
  always_comb begin
    last_idx  = is_unc_q ? '0 : CW'(LINE_WORD_NUM - 1);
    beat_last = (cnt_q == last_idx);
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    is_unc_d = is_unc_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    data_d   = data_q;
    case (state_q)
      S_IDLE: begin
        if (rd_req || rd_uncache) begin
          addr_d   = rd_addr;
          is_unc_d = rd_uncache;
          cnt_d    = '0;
          err_d    = 1'b0;
          state_d  = S_AR;
        end
      end
      S_AR: begin
        if (arready) state_d = S_R;
      end
      S_R: begin
        if (rvalid) begin
          if (is_unc_q) begin
            data_d                     = '0;
            data_d[LW-1 -: DATA_WIDTH] = rdata;
          end else begin
            for (int unsigned w = 0; w < LINE_WORD_NUM; w++) begin
              if (cnt_q == CW'(w)) data_d[w*DATA_WIDTH +: DATA_WIDTH] = rdata;
            end
          end
          cnt_d = (cnt_q == CW'(LINE_WORD_NUM - 1)) ? '0 : cnt_q + 1'b1;
          err_d = err_q | (rresp != 2'b00) | (rid != AXI_ID) | (rlast != beat_last);
          // Completion follows the beat count, never RLAST; a bad RLAST only flags an error.
          if (beat_last) state_d = S_RET;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_g) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      is_unc_q <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      is_unc_q <= is_unc_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    rd_rdy    = (state_q == S_IDLE);
    arvalid   = (state_q == S_AR);
    rready    = (state_q == S_R);
    ret_valid = (state_q == S_RET);
    ret_err   = (state_q == S_RET) & err_q;
    ret_data  = data_q;
    arid      = AXI_ID;
    araddr    = addr_q;
    arlen     = is_unc_q ? 8'd0 : 8'(LINE_WORD_NUM - 1);
    arsize    = 3'b010;
    arburst   = 2'b01;
  end

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Self-checking bench for icache_axi_rd_bridge: directed scenarios plus randomized
// transactions checked against a transaction-level model of the expected result.
module tb_icache_axi_rd_bridge;

  logic         clk_g = 1'b0;
  logic         rst, rd_req, rd_uncache;
  logic [31:0]  rd_addr;
  logic         rd_rdy, ret_valid, ret_err;
  logic [127:0] ret_data;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid, arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready;

  int n_tests = 0;
  int n_fail  = 0;

  icache_axi_rd_bridge #(.LINE_WORD_NUM(4), .DATA_WIDTH(32), .AXI_ID(4'd0)) dut (
    .clk_g(clk_g), .rst(rst), .rd_req(rd_req), .rd_uncache(rd_uncache), .rd_addr(rd_addr),
    .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_data(ret_data), .ret_err(ret_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial forever #5 clk_g = ~clk_g;

  // The icache never raises rd_uncache while the bridge is busy.
  always @(posedge clk_g) begin
    assert (rst || !rd_uncache || rd_rdy) else $error("rd_uncache raised while bridge busy");
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // Beat stimulus for the next transaction
  logic [31:0] b_data[4];
  logic [1:0]  b_resp[4];
  logic [3:0]  b_id[4];
  logic        b_last[4];

  // Observations from run_txn
  logic [127:0] o_data, o_hold;
  logic         o_err;
  int           o_ret_cyc, o_ar_cyc, o_pulses;
  logic [31:0]  o_araddr;
  logic [7:0]   o_arlen;
  logic [2:0]   o_arsize;
  logic [1:0]   o_arburst;
  logic [3:0]   o_arid;
  bit           o_ar_stable, o_rready_ok, o_extra_ar, o_busy_rdy, o_timeout;

  function automatic logic [127:0] model_data(input bit unc);
    logic [127:0] d;
    d = '0;
    if (unc) d[127:96] = b_data[0];
    else for (int k = 0; k < 4; k++) d[32*k +: 32] = b_data[k];
    return d;
  endfunction

  function automatic logic model_err(input bit unc);
    int nb;
    logic e;
    nb = unc ? 1 : 4;
    e  = 1'b0;
    for (int k = 0; k < nb; k++)
      e = e | (b_resp[k] != 2'b00) | (b_id[k] != 4'd0) | (b_last[k] != (k == nb - 1));
    return e;
  endfunction

  function automatic int model_ret_cyc(input bit unc, input int ar_wait, input int gap);
    return 2 + ar_wait + (unc ? 1 : 4) * (gap + 1);
  endfunction

  task automatic gen_beats(input bit unc);
    for (int k = 0; k < 4; k++) begin
      b_data[k] = $urandom;
      b_resp[k] = 2'b00;
      b_id[k]   = 4'd0;
      b_last[k] = (k == (unc ? 0 : 3));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; rd_req = 1'b0; rd_uncache = 1'b0; rd_addr = '0;
    arready = 1'b0; rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
    repeat (3) @(negedge clk_g);
    rst = 1'b0;
  endtask

  // Drives one request and its AXI responses; cycle 0 is the accept cycle.
  task automatic run_txn(input bit req, input bit unc, input logic [31:0] addr,
                         input int ar_wait, input int gap, input bit req_in_r);
    int cyc, nb;
    o_timeout = 0; o_ar_stable = 1; o_rready_ok = 1; o_extra_ar = 0; o_busy_rdy = 0;
    o_pulses = 0; o_ret_cyc = -1; o_ar_cyc = -1;
    for (int i = 0; i < 20 && !rd_rdy; i++) @(negedge clk_g);
    rd_req = req; rd_uncache = unc; rd_addr = addr;
    @(negedge clk_g); cyc = 1;
    rd_req = 1'b0; rd_uncache = 1'b0; rd_addr = $urandom;
    for (int i = 0; i < 40 && !arvalid; i++) begin @(negedge clk_g); cyc++; end
    if (!arvalid) begin o_timeout = 1; return; end
    o_ar_cyc = cyc; o_araddr = araddr; o_arlen = arlen; o_arsize = arsize;
    o_arburst = arburst; o_arid = arid;
    for (int i = 0; i < ar_wait; i++) begin
      @(negedge clk_g); cyc++;
      if (!arvalid || araddr != o_araddr || arlen != o_arlen || arid != o_arid) o_ar_stable = 0;
    end
    arready = 1'b1;
    @(negedge clk_g); cyc++;
    arready = 1'b0;
    nb = unc ? 1 : 4;
    if (req_in_r) rd_req = 1'b1;
    for (int k = 0; k < nb; k++) begin
      for (int g = 0; g < gap; g++) begin
        if (!rready) o_rready_ok = 0;
        if (arvalid) o_extra_ar = 1;
        if (rd_rdy) o_busy_rdy = 1;
        if (ret_valid) o_pulses++;
        @(negedge clk_g); cyc++;
      end
      if (!rready) o_rready_ok = 0;
      if (arvalid) o_extra_ar = 1;
      if (rd_rdy) o_busy_rdy = 1;
      rvalid = 1'b1; rdata = b_data[k]; rresp = b_resp[k]; rid = b_id[k]; rlast = b_last[k];
      @(negedge clk_g); cyc++;
      rvalid = 1'b0; rlast = 1'b0;
    end
    rd_req = 1'b0;
    for (int i = 0; i < 20 && !ret_valid; i++) begin @(negedge clk_g); cyc++; end
    if (!ret_valid) begin o_timeout = 1; return; end
    o_ret_cyc = cyc; o_data = ret_data; o_err = ret_err; o_pulses++;
    @(negedge clk_g);
    if (ret_valid) o_pulses++;
    o_hold = ret_data;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (rd_rdy !== 1'b1 || arvalid !== 1'b0 || rready !== 1'b0 || ret_valid !== 1'b0 || ret_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got rdy=%b arv=%b rrdy=%b rv=%b re=%b exp 1 0 0 0 0",
               rd_rdy, arvalid, rready, ret_valid, ret_err);
    end
    n_tests++;
    if (ret_data !== 128'd0) begin
      n_fail++; $display("FAIL reset_data got %h exp 0", ret_data);
    end
  endtask

  task automatic test_cached();
    logic [127:0] exp_d;
    b_data[0] = 32'h11; b_data[1] = 32'h22; b_data[2] = 32'h33; b_data[3] = 32'h44;
    for (int k = 0; k < 4; k++) begin b_resp[k] = 2'b00; b_id[k] = 4'd0; b_last[k] = (k == 3); end
    exp_d = 128'h00000044_00000033_00000022_00000011;
    run_txn(1'b1, 1'b0, 32'h1FC0_0010, 0, 0, 1'b0);
    n_tests++;
    if (o_timeout || o_araddr !== 32'h1FC0_0010 || o_arlen !== 8'd3 || o_arburst !== 2'b01 ||
        o_arsize !== 3'b010 || o_arid !== 4'd0) begin
      n_fail++;
      $display("FAIL cached_ar got addr=%h len=%0d burst=%0d size=%0d id=%0d to=%0b exp 1fc00010 3 1 2 0 0",
               o_araddr, o_arlen, o_arburst, o_arsize, o_arid, o_timeout);
    end
    n_tests++;
    if (o_data !== exp_d || o_err !== 1'b0) begin
      n_fail++; $display("FAIL cached_data got %h err=%b exp %h err=0", o_data, o_err, exp_d);
    end
    n_tests++;
    if (o_ar_cyc != 1 || o_ret_cyc != 6 || o_pulses != 1) begin
      n_fail++;
      $display("FAIL cached_latency got ar=%0d ret=%0d pulses=%0d exp 1 6 1", o_ar_cyc, o_ret_cyc, o_pulses);
    end
  endtask

  task automatic test_uncached();
    logic [127:0] exp_d;
    gen_beats(1'b1);
    b_data[0] = 32'hDEADBEEF;
    exp_d = {32'hDEADBEEF, 96'd0};
    run_txn(1'b0, 1'b1, 32'hBFC0_0000, 0, 0, 1'b0);
    n_tests++;
    if (o_timeout || o_arlen !== 8'd0 || o_araddr !== 32'hBFC0_0000) begin
      n_fail++; $display("FAIL uncached_ar got len=%0d addr=%h exp 0 bfc00000", o_arlen, o_araddr);
    end
    n_tests++;
    if (o_data !== exp_d || o_err !== 1'b0 || o_ret_cyc != 3) begin
      n_fail++;
      $display("FAIL uncached_ret got %h err=%b cyc=%0d exp %h err=0 cyc=3", o_data, o_err, o_ret_cyc, exp_d);
    end
  endtask

  task automatic test_stall();
    gen_beats(1'b0);
    run_txn(1'b1, 1'b0, 32'h0000_1230, 5, 2, 1'b0);
    n_tests++;
    if (o_timeout || !o_ar_stable || o_araddr !== 32'h0000_1230 || !o_rready_ok) begin
      n_fail++;
      $display("FAIL stall_hold got ar_stable=%0b addr=%h rready_ok=%0b exp 1 00001230 1",
               o_ar_stable, o_araddr, o_rready_ok);
    end
    n_tests++;
    if (o_data !== model_data(1'b0) || o_pulses != 1 || o_ret_cyc != model_ret_cyc(1'b0, 5, 2)) begin
      n_fail++;
      $display("FAIL stall_ret got %h pulses=%0d cyc=%0d exp %h 1 %0d",
               o_data, o_pulses, o_ret_cyc, model_data(1'b0), model_ret_cyc(1'b0, 5, 2));
    end
  endtask

  task automatic test_error();
    gen_beats(1'b0);
    b_resp[1] = 2'b10;
    run_txn(1'b1, 1'b0, 32'h0000_2000, 0, 0, 1'b0);
    n_tests++;
    if (o_err !== 1'b1 || o_ret_cyc != 6 || o_data !== model_data(1'b0)) begin
      n_fail++; $display("FAIL slverr_flag got err=%b cyc=%0d exp err=1 cyc=6", o_err, o_ret_cyc);
    end
    gen_beats(1'b0);
    run_txn(1'b1, 1'b0, 32'h0000_2040, 0, 0, 1'b0);
    n_tests++;
    if (o_err !== 1'b0 || o_timeout) begin
      n_fail++; $display("FAIL err_cleared got err=%b exp 0", o_err);
    end
  endtask

  task automatic test_priority();
    gen_beats(1'b1);
    run_txn(1'b1, 1'b1, 32'h0000_3004, 0, 0, 1'b0);
    n_tests++;
    if (o_arlen !== 8'd0 || o_data !== model_data(1'b1) || o_ret_cyc != 3) begin
      n_fail++;
      $display("FAIL both_req_unc got len=%0d data=%h cyc=%0d exp 0 %h 3", o_arlen, o_data, o_ret_cyc, model_data(1'b1));
    end
    gen_beats(1'b0);
    run_txn(1'b1, 1'b0, 32'h0000_3100, 1, 1, 1'b1);
    n_tests++;
    if (o_extra_ar || o_busy_rdy || o_pulses != 1 || o_data !== model_data(1'b0)) begin
      n_fail++;
      $display("FAIL req_in_r got extra_ar=%0b rdy_busy=%0b pulses=%0d exp 0 0 1", o_extra_ar, o_busy_rdy, o_pulses);
    end
    @(negedge clk_g);
    n_tests++;
    if (arvalid !== 1'b0 || rd_rdy !== 1'b1) begin
      n_fail++; $display("FAIL req_in_r_queued got arvalid=%b rdy=%b exp 0 1", arvalid, rd_rdy);
    end
  endtask

  task automatic test_reset_mid();
    rd_req = 1'b1; rd_addr = 32'h0000_4000;
    @(negedge clk_g);
    rd_req = 1'b0;
    for (int i = 0; i < 10 && !arvalid; i++) @(negedge clk_g);
    arready = 1'b1;
    @(negedge clk_g);
    arready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rvalid = 1'b1; rdata = $urandom; rresp = 2'b00; rid = 4'd0; rlast = 1'b0;
      @(negedge clk_g);
    end
    rvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk_g);
    n_tests++;
    if (rd_rdy !== 1'b1 || ret_valid !== 1'b0 || rready !== 1'b0 || arvalid !== 1'b0 || ret_data !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_mid got rdy=%b rv=%b rrdy=%b arv=%b data=%h exp 1 0 0 0 0",
               rd_rdy, ret_valid, rready, arvalid, ret_data);
    end
    rst = 1'b0;
    gen_beats(1'b0);
    run_txn(1'b1, 1'b0, 32'h0000_4040, 0, 0, 1'b0);
    n_tests++;
    if (o_data !== model_data(1'b0) || o_err !== 1'b0 || o_ret_cyc != 6) begin
      n_fail++; $display("FAIL after_reset got %h err=%b cyc=%0d exp %h 0 6", o_data, o_err, o_ret_cyc, model_data(1'b0));
    end
  endtask

  task automatic test_random();
    bit unc;
    int aw, gp, nb, sel, kind;
    logic [31:0] addr;
    for (int t = 0; t < 30; t++) begin
      unc  = ($urandom_range(0, 2) == 0);
      aw   = $urandom_range(0, 3);
      gp   = $urandom_range(0, 2);
      addr = unc ? ($urandom & 32'hFFFF_FFFC) : ($urandom & 32'hFFFF_FFF0);
      nb   = unc ? 1 : 4;
      gen_beats(unc);
      if ($urandom_range(0, 3) == 0) begin
        sel  = $urandom_range(0, nb - 1);
        kind = $urandom_range(0, 2);
        if (kind == 0) b_resp[sel] = 2'($urandom_range(1, 3));
        else if (kind == 1) b_id[sel] = 4'($urandom_range(1, 15));
        else b_last[sel] = ~b_last[sel];
      end
      run_txn(!unc || ($urandom_range(0, 1) == 1), unc, addr, aw, gp, 1'b0);
      n_tests++;
      if (o_timeout || o_araddr !== addr || o_arlen !== 8'(nb - 1) || o_ret_cyc != model_ret_cyc(unc, aw, gp)) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d] got addr=%h len=%0d cyc=%0d exp %h %0d %0d", t,
                 o_araddr, o_arlen, o_ret_cyc, addr, nb - 1, model_ret_cyc(unc, aw, gp));
      end
      n_tests++;
      if (o_data !== model_data(unc) || o_err !== model_err(unc) || o_hold !== o_data || o_pulses != 1) begin
        n_fail++;
        $display("FAIL rand_ret[%0d] got %h err=%b hold=%h pulses=%0d exp %h err=%b", t,
                 o_data, o_err, o_hold, o_pulses, model_data(unc), model_err(unc));
      end
    end
  endtask

  initial begin
    test_reset();
    test_cached();
    test_uncached();
    test_stall();
    test_error();
    test_priority();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_axi_rd_bridge.md
Name: icache_axi_rd_bridge

Overview:
- Responder for the instruction cache's refill/uncached-read port.
- Accepts one line request (rd_req) or single-word uncached request (rd_uncache) at a time and converts it to one AXI4 read transaction: 4-beat INCR burst for lines, single beat for uncached reads.
- Returns the assembled 128-bit result with a one-cycle ret_valid pulse.
- Sits between the icache and the AXI read arbiter/crossbar.

Parameters:
- LINE_WORD_NUM, 4, words per cache line; ARLEN for cached reads = LINE_WORD_NUM-1.
- DATA_WIDTH, 32, AXI data width and word size; ARSIZE = 3'b010.
- AXI_ID, 4'd0, constant ARID driven on every request; RID must equal it.

Ports:
- clk_g  in  1  clock
- rst  in  1  synchronous active-high reset
- rd_req  in  1  cached line read request (level, held until accepted)
- rd_uncache  in  1  uncached word read request
- rd_addr  in  32  request address (line-aligned for cached reads)
- rd_rdy  out  1  bridge can accept a request this cycle
- ret_valid  out  1  one-cycle pulse: ret_data valid
- ret_data  out  128  line data; uncached word in [127:96]
- ret_err  out  1  pulses with ret_valid if any RRESP!=OKAY, RID mismatch or RLAST misplacement
- arid  out  4  read address ID
- araddr  out  32  read address
- arlen  out  8  burst length-1
- arsize  out  3  3'b010
- arburst  out  2  2'b01 INCR
- arvalid  out  1  address valid
- arready  in  1  address ready
- rid  in  4  read ID
- rdata  in  32  read data
- rresp  in  2  read response
- rlast  in  1  last beat
- rvalid  in  1  data valid
- rready  out  1  data ready

Behaviour:
- Single clock clk_g. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, arvalid=0, rready=0, ret_valid=0, ret_err=0, ret_data=0, beat counter=0.
- rst mid-transaction aborts immediately. Any in-flight AXI beats are the interconnect's responsibility; they are not forwarded.

State machine (IDLE, AR, R, RET):
- IDLE:
  - rd_rdy=1, combinationally; rd_rdy is 0 in all other states.
  - Accept when rd_req|rd_uncache. Latch rd_addr and is_unc=rd_uncache; rd_uncache has priority if both are asserted.
  - Clear beat counter and error flag; go to AR.
- AR:
  - arvalid=1, araddr=latched addr, arlen=is_unc?0:LINE_WORD_NUM-1, arid=AXI_ID.
  - arvalid and all AR fields stay stable until arready. On arvalid&arready go to R.
- R:
  - rready=1.
  - On each rvalid: cached beat k writes ret_data[32k+31:32k]; uncached beat writes [127:96], other bits are 0.
  - Counter k increments and wraps modulo LINE_WORD_NUM.
  - Error flag |= (rresp!=0) | (rid!=AXI_ID) | (rlast != (k==arlen)).
  - Completion is on the beat where k==arlen, regardless of rlast; then go to RET.
- RET:
  - ret_valid=1 and ret_err=error flag for exactly one cycle; go to IDLE.
  - ret_data holds its value until the first beat of the next transaction.
- Latency with zero-wait AXI:
  - Request accepted at cycle 0, arvalid at cycles 1..; AR handshake at cycle 1.
  - Beats at cycles 2..5; ret_valid at cycle 6 (cached) or cycle 3 (uncached).
  - The next request can be accepted the cycle after ret_valid.
- Requests while rd_rdy=0 are ignored and not queued. The icache only asserts rd_uncache when rd_rdy=1; any violation is flagged by a bench assertion.
- At most one outstanding AXI transaction.

Test Plan:
- Cached read, addr 0x1FC0_0010, arready=1, beats 0x11,0x22,0x33,0x44 with rlast on beat 4 -> araddr=0x1FC0_0010, arlen=3, arburst=1; ret_data=0x00000044_00000033_00000022_00000011; ret_valid at cycle 6; ret_err=0.
- Uncached read, addr 0xBFC0_0000, rdata=0xDEADBEEF -> arlen=0; ret_data[127:96]=0xDEADBEEF with other bits 0; ret_valid at cycle 3.
- arready held low 5 cycles, rvalid gaps of 2 cycles between beats -> arvalid and araddr stable throughout; rready stays 1; correct data; single ret_valid pulse.
- rresp=2'b10 on beat 2 of a cached read -> ret_valid together with ret_err=1; next request has ret_err=0.
- rd_req and rd_uncache asserted together -> treated as uncached (arlen=0). rd_req asserted during R -> ignored, rd_rdy=0, no second AR.
- rst asserted in R after 2 beats -> next cycle state IDLE, rd_rdy=1, ret_valid=0, rready=0, arvalid=0.
